line_stepper: RTL and testbench



---
 rtl/line_stepper.sv | 114 +++++++++++
 tb/tb_line_stepper.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/line_stepper.sv
// Bresenham stepping stage: orders swapped endpoints left-to-right, steps x one
// pixel per transfer and un-swaps (x,y) for the fragment writer.
module line_stepper #(
    parameter int WIDTH = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    steep,
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] y1,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic signed [WIDTH-1:0] pix_x,
    output logic signed [WIDTH-1:0] pix_y,
    output logic                    pix_last,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    localparam logic signed [WIDTH-1:0] ONE = 1;

    state_t                  r_state, w_next;
    logic                    r_steep, r_yneg;
    logic signed [WIDTH-1:0] r_xs, r_ys, r_xe, r_ye, r_cx, r_cy;
    logic        [WIDTH:0]   r_dx, r_dy;
    logic signed [WIDTH+1:0] r_err;

    logic                    w_accept, w_xfer, w_last;
    logic signed [WIDTH:0]   w_dxs, w_dys, w_dy;
    logic signed [WIDTH+1:0] w_t;

    assign in_ready  = (r_state == IDLE);
    assign busy      = !in_ready;
    assign pix_valid = (r_state == DRAW);
    assign w_last    = (r_cx == r_xe);
    assign pix_last  = pix_valid && w_last;
    assign pix_x     = r_steep ? r_cy : r_cx;
    assign pix_y     = r_steep ? r_cx : r_cy;

    assign w_accept = in_valid && in_ready;
    assign w_xfer   = pix_valid && pix_ready;

    // One extra bit so full-range spans (up to 2^WIDTH-1) never wrap.
    assign w_dxs = {r_xe[WIDTH-1], r_xe} - {r_xs[WIDTH-1], r_xs};
    assign w_dys = {r_ye[WIDTH-1], r_ye} - {r_ys[WIDTH-1], r_ys};
    assign w_dy  = w_dys[WIDTH] ? -w_dys : w_dys;
    assign w_t   = r_err - $signed({1'b0, r_dy});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = DRAW;
            DRAW:    if (w_xfer && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_steep <= 1'b0;
            r_yneg  <= 1'b0;
            r_xs    <= '0;
            r_ys    <= '0;
            r_xe    <= '0;
            r_ye    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_steep <= steep;
                    if (x0 > x1) begin
                        r_xs <= x1; r_ys <= y1; r_xe <= x0; r_ye <= y0;
                    end else begin
                        r_xs <= x0; r_ys <= y0; r_xe <= x1; r_ye <= y1;
                    end
                end
                SETUP: begin
                    r_dx   <= w_dxs;
                    r_dy   <= w_dy;
                    r_yneg <= !(r_ys < r_ye);
                    r_err  <= $signed({2'b00, w_dxs[WIDTH:1]});
                    r_cx   <= r_xs;
                    r_cy   <= r_ys;
                end
                DRAW: if (w_xfer && !w_last) begin
                    r_cx <= r_cx + ONE;
                    if (w_t < 0) begin
                        r_cy  <= r_yneg ? r_cy - ONE : r_cy + ONE;
                        r_err <= w_t + $signed({1'b0, r_dx});
                    end else begin
                        r_err <= w_t;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_stepper.sv
// Directed bench for line_stepper: hand-computed pixel sequences, latency,
// backpressure stability, boundary lines and mid-line reset.
module tb_line_stepper;

    localparam int W = 13;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                steep = 1'b0;
    logic signed [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic                pix_valid;
    logic                pix_ready = 1'b0;
    logic signed [W-1:0] pix_x, pix_y;
    logic                pix_last;
    logic                busy;

    int n_chk  = 0;
    int n_pass = 0;

    int got_x[$], got_y[$], got_l[$];
    int stall_bad;
    int timeout;

    always #5 clk = ~clk;

    line_stepper #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .steep(steep), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
        .pix_y(pix_y), .pix_last(pix_last), .busy(busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Accept one line, then collect pixels. bp=1 applies pix_ready 1,0,0,1,...
    task automatic run_line(input logic st, input int ax0, input int ay0,
                            input int ax1, input int ay1, input bit bp);
        int  k;
        bit  held;
        int  hx, hy, hl;
        bit  done;
        got_x.delete(); got_y.delete(); got_l.delete();
        stall_bad = 0;
        timeout   = 0;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        steep = st; x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; steep = 1'b0;
        chk("setup_no_valid", pix_valid, 0);
        chk("setup_busy", busy, 1);
        @(negedge clk);
        chk("first_valid_lat", pix_valid, 1);
        k = 0; held = 0; done = 0; hx = 0; hy = 0; hl = 0;
        while (!done) begin
            pix_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            if (held && (pix_x != hx || pix_y != hy || pix_last != hl[0] || !pix_valid))
                stall_bad++;
            if (in_ready) stall_bad++;
            if (pix_valid && pix_ready) begin
                got_x.push_back(int'(pix_x));
                got_y.push_back(int'(pix_y));
                got_l.push_back(int'(pix_last));
                held = 0;
                if (pix_last) done = 1;
            end else begin
                held = pix_valid; hx = pix_x; hy = pix_y; hl = pix_last;
            end
            k++;
            if (k > 20000) begin timeout = 1; done = 1; end
            @(negedge clk);
        end
        pix_ready = 1'b0;
        chk("timeout", timeout, 0);
        chk("in_ready_after", in_ready, 1);
        chk("valid_after", pix_valid, 0);
    endtask

    task automatic cmp_seq(input string tag, input int ex[], input int ey[]);
        chk({tag, "_count"}, got_x.size(), ex.size());
        for (int i = 0; i < ex.size() && i < got_x.size(); i++) begin
            chk({tag, "_x"}, got_x[i], ex[i]);
            chk({tag, "_y"}, got_y[i], ey[i]);
            chk({tag, "_last"}, got_l[i], (i == ex.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int ex[], ey[];
        int bad_y, bad_x;

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_last", pix_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        #22 rst_n = 1'b1;

        ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 1, 1, 2};
        run_line(1'b0, 0, 0, 4, 2, 1'b0);
        cmp_seq("basic", ex, ey);

        ex = '{0, 0, 1, 1}; ey = '{0, 1, 2, 3};
        run_line(1'b1, 0, 0, 3, 1, 1'b0);
        cmp_seq("steep", ex, ey);

        ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 1, 1, 2};
        run_line(1'b0, 4, 2, 0, 0, 1'b0);
        cmp_seq("reversed", ex, ey);

        ex = '{0, 1, 2, 3, 4}; ey = '{2, 2, 1, 1, 0};
        run_line(1'b0, 0, 2, 4, 0, 1'b0);
        cmp_seq("neg_ystep", ex, ey);

        ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 1, 1, 2};
        run_line(1'b0, 0, 0, 4, 2, 1'b1);
        cmp_seq("backpressure", ex, ey);
        chk("bp_stable", stall_bad, 0);

        ex = '{7}; ey = '{-3};
        run_line(1'b0, 7, -3, 7, -3, 1'b0);
        cmp_seq("single", ex, ey);

        run_line(1'b0, -4096, 0, 4095, 0, 1'b0);
        chk("long_count", got_x.size(), 8192);
        bad_y = 0; bad_x = 0;
        for (int i = 0; i < got_x.size(); i++) begin
            if (got_y[i] != 0) bad_y++;
            if (got_x[i] != -4096 + i) bad_x++;
        end
        chk("long_y_const", bad_y, 0);
        chk("long_x_seq", bad_x, 0);
        chk("long_last", got_l[got_l.size() - 1], 1);

        // Reset after the second pixel of the basic line.
        @(negedge clk);
        steep = 1'b0; x0 = 0; y0 = 0; x1 = 4; y1 = 2; in_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pix0_x", pix_x, 0);
        @(negedge clk);
        chk("mid_pix1_x", pix_x, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", pix_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        pix_ready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("mid_rst_hold_valid", pix_valid, 0);

        ex = '{0, 0, 1, 1}; ey = '{0, 1, 2, 3};
        run_line(1'b1, 0, 0, 3, 1, 1'b0);
        cmp_seq("after_rst", ex, ey);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
